read_counter: RTL and testbench
===============================

READ_COUNTER -- requirements
Module: read_counter

Interface
REQ-001 Parameter RATE_DIV, default 8: clk cycles between count strobes; legal range 2..255.
REQ-002 Parameter BACKLOG_MAX, default 7: magnitude limit of pending count backlog; legal range 1..15.
REQ-003 clk  in  1  system clock; single clock domain.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 up_req  in  1  one-cycle request from error detector: advance angle one step.
REQ-006 dn_req  in  1  one-cycle request from error detector: retard angle one step.
REQ-007 coarse_err  in  1  coarse-system error exceeds threshold (level).
REQ-008 zero_cdu  in  1  one-cycle command: zero counter and re-enter coarse mode.
REQ-009 angle  out  16  read counter; LSB = 360/65536 deg.
REQ-010 _D1.._D14  out  1 each  active-low switch drives to quadrant selector.
REQ-011 plus_pulse, minus_pulse  out  1 each  one-cycle pulse per fine LSB applied (to AGC counter interface).
REQ-012 fine_mode  out  1  high while FSM in FINE.

Function
REQ-013 Strobe counter SHALL run 0..RATE_DIV-1 free, strobe asserted on terminal count; zero_cdu restarts it at 0.
REQ-014 Backlog SHALL be signed: +1 on up_req, -1 on dn_req, unchanged if both or neither asserted same cycle.
REQ-015 Backlog SHALL saturate at +/-BACKLOG_MAX; requests beyond limit discarded.
REQ-016 On strobe with backlog nonzero: angle SHALL step by sign(backlog) x step, backlog moves one toward zero; an input request in the same cycle is also applied to the backlog.
REQ-017 Step SHALL be 1 in FINE, 64 in COARSE; angle wraps modulo 65536 both directions (0xFFFF+1=0x0000, 0x0000-1=0xFFFF).
REQ-018 plus_pulse/minus_pulse SHALL fire the cycle after a FINE-mode step only; COARSE steps emit no pulses.
REQ-019 FSM states COARSE, FINE; COARSE->FINE after coarse_err low on 4 consecutive strobes; FINE->COARSE on any strobe with coarse_err high; non-strobe cycles do not advance the qualification count.
REQ-020 zero_cdu SHALL clear angle, backlog, qualification count and force COARSE, taking priority over all same-cycle requests.
REQ-021 Drives SHALL be registered, one cycle after angle update: _D1.._D4 one-hot low decoded from angle[12:11] (00->_D1 ... 11->_D4).
REQ-022 _D5 = angle[15] (sine negative); _D7 = angle[15] XOR angle[14] (cosine negative); _D6, _D8 held high.
REQ-023 FINE: _D9=0, _D12=0, _D10=1, _D13=1; COARSE: _D9=1, _D12=1, _D10=0, _D13=0.
REQ-024 _D11 = angle[13]; _D14 = ~angle[13] (mutually exclusive feedback select, never both low).
REQ-025 _D1.._D4 SHALL never have more than one low simultaneously.

Reset
REQ-026 On rst: angle=0, backlog=0, strobe counter=0, qualification=0, state COARSE, pulses low, fine_mode=0.
REQ-027 Drives after rst: _D1=0, _D2.._D4=1, _D5=0, _D7=0, _D6=_D8=1, _D9=_D12=1, _D10=_D13=0, _D11=0, _D14=1.
REQ-028 rst mid-step SHALL discard backlog and suppress any pending pulse.

Structure
REQ-029 Shared package cdu_pkg: FSM state enum, STEP_FINE=1, STEP_COARSE=64, QUAL_STROBES=4.
REQ-030 One sub-module, cdu_switch_decode: purely combinational angle+state -> _D1.._D14, registered in parent.

Verification
REQ-031 Reset, coarse_err=1, 3 up_req spaced 1 cycle -> angle 0->64->128->192 on successive strobes, no plus_pulse.
REQ-032 coarse_err=0 for 4 strobes -> fine_mode=1, _D9=0, _D10=1; next up_req -> angle+1 and plus_pulse one cycle later.
REQ-033 FINE, angle=0x0000, dn_req -> angle=0xFFFF, minus_pulse, _D5=1, _D7=0, _D4=0.
REQ-034 20 up_req back-to-back -> backlog caps at 7, exactly 7 steps applied over following strobes.
REQ-035 up_req and dn_req same cycle -> backlog unchanged, no step.
REQ-036 Backlog 5 in FINE, zero_cdu with up_req same cycle -> angle=0, backlog=0, COARSE, no pulses.

Source files
------------

// File: rtl/cdu_pkg.sv
// cdu_pkg: shared state encoding and step constants for the CDU read counter
package cdu_pkg;
  typedef enum logic {COARSE, FINE} cdu_state_e;
  localparam logic [15:0] STEP_FINE = 16'd1;
  localparam logic [15:0] STEP_COARSE = 16'd64;
  localparam int QUAL_STROBES = 4;
  localparam logic [13:0] DRV_RST = 14'b10100110101110;
endpackage

// File: rtl/cdu_switch_decode.sv
// cdu_switch_decode: angle high bits and mode to active-low switch drives (bit 0 = _D1)
module cdu_switch_decode
  import cdu_pkg::*;
(
  input  logic [4:0]  i_ang_hi,
  input  cdu_state_e  i_state,
  output logic [13:0] o_drv
);
  logic w_fine;
  assign w_fine = i_state == FINE;
  assign o_drv = {~i_ang_hi[2], w_fine, ~w_fine, i_ang_hi[2], w_fine, ~w_fine, 1'b1,
                  i_ang_hi[4] ^ i_ang_hi[3], 1'b1, i_ang_hi[4], ~(4'b0001 << i_ang_hi[1:0])};
endmodule

// File: rtl/read_counter.sv
// read_counter: rate-limited CDU read counter with coarse/fine FSM and quadrant switch drives
module read_counter
  import cdu_pkg::*;
#(
  parameter int RATE_DIV = 8,
  parameter int BACKLOG_MAX = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up_req,
  input  logic        dn_req,
  input  logic        coarse_err,
  input  logic        zero_cdu,
  output logic [15:0] angle,
  output logic        _D1, _D2, _D3, _D4, _D5, _D6, _D7,
  output logic        _D8, _D9, _D10, _D11, _D12, _D13, _D14,
  output logic        plus_pulse,
  output logic        minus_pulse,
  output logic        fine_mode
);
  localparam logic signed [5:0] BL_MAX = 6'(BACKLOG_MAX);
  localparam logic signed [5:0] BL_MIN = -BL_MAX;
  logic [7:0] r_div;
  logic signed [4:0] r_backlog;
  logic [15:0] r_angle;
  cdu_state_e r_state, w_state_nxt;
  logic [1:0] r_qual, w_qual_nxt;
  logic r_pend_up, r_pend_dn, r_plus, r_minus;
  logic [13:0] r_drv, w_drv;
  logic w_strobe, w_step_up, w_step_dn;
  logic signed [5:0] w_req, w_dec, w_bl_sum;
  logic [4:0] w_bl_next;
  logic [15:0] w_step;
  assign w_strobe = r_div == 8'(RATE_DIV - 1);
  assign w_step_up = w_strobe && r_backlog > 5'sd0;
  assign w_step_dn = w_strobe && r_backlog < 5'sd0;
  assign w_req = (up_req && !dn_req) ? 6'sd1 : (dn_req && !up_req) ? -6'sd1 : 6'sd0;
  assign w_dec = w_step_up ? 6'sd1 : w_step_dn ? -6'sd1 : 6'sd0;
  assign w_bl_sum = {r_backlog[4], r_backlog} + w_req - w_dec;
  assign w_bl_next = w_bl_sum > BL_MAX ? BL_MAX[4:0] : w_bl_sum < BL_MIN ? BL_MIN[4:0] : w_bl_sum[4:0];
  assign w_step = r_state == FINE ? STEP_FINE : STEP_COARSE;
  always_comb begin
    w_state_nxt = r_state;
    w_qual_nxt = r_qual;
    if (w_strobe && coarse_err) begin
      w_state_nxt = COARSE;
      w_qual_nxt = '0;
    end else if (w_strobe && r_state == COARSE) begin
      w_state_nxt = r_qual == 2'(QUAL_STROBES - 1) ? FINE : COARSE;
      w_qual_nxt = r_qual == 2'(QUAL_STROBES - 1) ? 2'd0 : r_qual + 2'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || zero_cdu) begin
      r_div <= '0;
      r_backlog <= '0;
      r_angle <= '0;
      r_state <= COARSE;
      r_qual <= '0;
      r_pend_up <= 1'b0;
      r_pend_dn <= 1'b0;
      r_plus <= 1'b0;
      r_minus <= 1'b0;
    end else begin
      r_div <= w_strobe ? 8'd0 : r_div + 8'd1;
      r_backlog <= w_bl_next;
      r_angle <= w_step_up ? r_angle + w_step : w_step_dn ? r_angle - w_step : r_angle;
      r_state <= w_state_nxt;
      r_qual <= w_qual_nxt;
      r_pend_up <= w_step_up && r_state == FINE;
      r_pend_dn <= w_step_dn && r_state == FINE;
      r_plus <= r_pend_up;
      r_minus <= r_pend_dn;
    end
  end
  // drives lag the angle by one cycle, zero_cdu lets them follow the cleared angle
  always_ff @(posedge clk) r_drv <= rst ? DRV_RST : w_drv;
  cdu_switch_decode u_dec (
    .i_ang_hi(r_angle[15:11]),
    .i_state (r_state),
    .o_drv   (w_drv)
  );
  assign angle = r_angle;
  assign plus_pulse = r_plus;
  assign minus_pulse = r_minus;
  assign fine_mode = r_state == FINE;
  assign {_D14, _D13, _D12, _D11, _D10, _D9, _D8, _D7, _D6, _D5, _D4, _D3, _D2, _D1} = r_drv;
endmodule

// File: tb/tb_read_counter.sv
// tb_read_counter: directed and random stimulus against a cycle-level behavioural model
module tb_read_counter;
  localparam int RATE_DIV = 8;
  localparam int BACKLOG_MAX = 7;
  logic clk = 0, rst = 1, up_req = 0, dn_req = 0, coarse_err = 0, zero_cdu = 0;
  logic [15:0] angle;
  logic _D1, _D2, _D3, _D4, _D5, _D6, _D7, _D8, _D9, _D10, _D11, _D12, _D13, _D14;
  logic plus_pulse, minus_pulse, fine_mode;
  logic [13:0] drv;
  int nchk = 0, npass = 0;
  int m_angle = 0, m_bl = 0, m_div = 0, m_qual = 0, m_fine = 0, m_pend = 0, m_plus = 0, m_minus = 0;
  logic [13:0] m_drv;
  always #5 clk = ~clk;
  assign drv = {_D14, _D13, _D12, _D11, _D10, _D9, _D8, _D7, _D6, _D5, _D4, _D3, _D2, _D1};
  read_counter #(.RATE_DIV(RATE_DIV), .BACKLOG_MAX(BACKLOG_MAX)) dut (
    .clk(clk), .rst(rst), .up_req(up_req), .dn_req(dn_req), .coarse_err(coarse_err),
    .zero_cdu(zero_cdu), .angle(angle),
    ._D1(_D1), ._D2(_D2), ._D3(_D3), ._D4(_D4), ._D5(_D5), ._D6(_D6), ._D7(_D7),
    ._D8(_D8), ._D9(_D9), ._D10(_D10), ._D11(_D11), ._D12(_D12), ._D13(_D13), ._D14(_D14),
    .plus_pulse(plus_pulse), .minus_pulse(minus_pulse), .fine_mode(fine_mode)
  );
  function automatic logic [13:0] drv_of(int a, int f);
    logic [13:0] v;
    int q = (a / 2048) % 4;
    int s15 = a >= 32768 ? 1 : 0;
    int s14 = (a / 16384) % 2;
    int s13 = (a / 8192) % 2;
    v = '1;
    v[q] = 1'b0;
    v[4] = s15 != 0;
    v[6] = s15 != s14;
    v[8] = f == 0;
    v[9] = f != 0;
    v[10] = s13 != 0;
    v[11] = f == 0;
    v[12] = f != 0;
    v[13] = s13 == 0;
    return v;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else $error("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic clear_model();
    m_angle = 0; m_bl = 0; m_div = 0; m_qual = 0; m_fine = 0; m_pend = 0; m_plus = 0; m_minus = 0;
  endtask
  task automatic model(input bit r, input bit u, input bit d, input bit e, input bit z);
    int sg, req;
    bit strobe;
    if (r) begin
      clear_model();
      m_drv = drv_of(0, 0);
    end else begin
      m_drv = drv_of(m_angle, m_fine);
      if (z) clear_model();
      else begin
        strobe = m_div == RATE_DIV - 1;
        m_plus = m_pend > 0;
        m_minus = m_pend < 0;
        sg = !strobe ? 0 : m_bl > 0 ? 1 : m_bl < 0 ? -1 : 0;
        m_pend = m_fine ? sg : 0;
        m_angle = (m_angle + sg * (m_fine ? 1 : 64) + 65536) % 65536;
        req = (u && !d) ? 1 : (d && !u) ? -1 : 0;
        m_bl = m_bl - sg + req;
        if (m_bl > BACKLOG_MAX) m_bl = BACKLOG_MAX;
        if (m_bl < -BACKLOG_MAX) m_bl = -BACKLOG_MAX;
        if (strobe && e) begin
          m_fine = 0; m_qual = 0;
        end else if (strobe && !m_fine) begin
          m_qual++;
          if (m_qual == 4) begin m_fine = 1; m_qual = 0; end
        end
        m_div = strobe ? 0 : m_div + 1;
      end
    end
  endtask
  task automatic tick(input bit r, input bit u, input bit d, input bit e, input bit z);
    rst = r; up_req = u; dn_req = d; coarse_err = e; zero_cdu = z;
    @(posedge clk);
    model(r, u, d, e, z);
    #1;
    chk("angle", 32'(angle), 32'(m_angle));
    chk("fine_mode", 32'(fine_mode), 32'(m_fine));
    chk("plus_pulse", 32'(plus_pulse), 32'(m_plus));
    chk("minus_pulse", 32'(minus_pulse), 32'(m_minus));
    chk("drives", 32'(drv), 32'(m_drv));
    chk("quad_onehot", 32'($countones(~drv[3:0]) <= 1), 32'(1));
  endtask
  task automatic idle(input int n, input bit e);
    for (int i = 0; i < n; i++) tick(0, 0, 0, e, 0);
  endtask
  initial begin
    tick(1, 0, 0, 1, 0);
    tick(1, 0, 0, 1, 0);
    chk("rst_angle", 32'(angle), 32'h0);
    chk("rst_drives", 32'(drv), 32'b10100110101110);
    // coarse steps of 64, no pulses
    tick(0, 1, 0, 1, 0); tick(0, 0, 0, 1, 0);
    tick(0, 1, 0, 1, 0); tick(0, 0, 0, 1, 0);
    tick(0, 1, 0, 1, 0);
    idle(30, 1);
    chk("coarse_192", 32'(angle), 32'd192);
    idle(40, 0);
    chk("fine_entered", 32'(fine_mode), 32'd1);
    chk("fine_d9", 32'(_D9), 32'd0);
    chk("fine_d10", 32'(_D10), 32'd1);
    tick(0, 1, 0, 0, 0);
    idle(20, 0);
    chk("fine_193", 32'(angle), 32'd193);
    // wrap below zero in fine mode
    tick(0, 0, 0, 0, 1);
    idle(40, 0);
    tick(0, 0, 1, 0, 0);
    idle(20, 0);
    chk("wrap_angle", 32'(angle), 32'hFFFF);
    chk("wrap_d5", 32'(_D5), 32'd1);
    chk("wrap_d7", 32'(_D7), 32'd0);
    chk("wrap_d4", 32'(_D4), 32'd0);
    // saturation burst
    for (int i = 0; i < 20; i++) tick(0, 1, 0, 0, 0);
    idle(80, 0);
    tick(0, 1, 1, 0, 0);
    idle(20, 0);
    // zero with backlog pending in fine mode
    for (int i = 0; i < 5; i++) tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 1);
    chk("zero_angle", 32'(angle), 32'h0);
    chk("zero_coarse", 32'(fine_mode), 32'd0);
    idle(20, 0);
    chk("zero_no_backlog", 32'(angle), 32'h0);
    for (int i = 0; i < 800; i++)
      tick($urandom_range(199) == 0, $urandom_range(2) == 0, $urandom_range(2) == 0,
           $urandom_range(5) == 0, $urandom_range(59) == 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
